// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte requesters.
// Each frame ends on tx_done or a programmable timeout, followed by a fixed idle gap.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned IDX_W      = 2,
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned TO_W       = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_sta,
  output logic [7:0]           tx_data,
  input  logic                 tx_done,
  input  logic [TO_W-1:0]      timeout_cycles,
  output logic                 busy,
  output logic [IDX_W-1:0]     grant_id,
  output logic                 timeout_err
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [TO_W-1:0]      cnt_q, cnt_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 tx_sta_q, tx_sta_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic                 busy_q, busy_d;
  logic [IDX_W-1:0]     grant_id_q, grant_id_d;
  logic                 timeout_err_q, timeout_err_d;

  logic                 found_c;
  logic [IDX_W-1:0]     sel_c;
  logic [IDX_W-1:0]     scan_idx_c;
  logic [7:0]           sel_byte_c;

  // First valid requester scanning ptr+1, ptr+2, ... modulo NUM_REQ.
  always_comb begin
    found_c    = 1'b0;
    sel_c      = '0;
    scan_idx_c = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      scan_idx_c = IDX_W'((32'(ptr_q) + i) % NUM_REQ);
      if (!found_c && req_valid[scan_idx_c]) begin
        found_c = 1'b1;
        sel_c   = scan_idx_c;
      end
    end
  end

  always_comb begin
    sel_byte_c = 8'h00;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == sel_c) sel_byte_c = req_data[i*8 +: 8];
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    gap_d         = gap_q;
    tx_sta_d      = tx_sta_q;
    tx_data_d     = tx_data_q;
    busy_d        = busy_q;
    grant_id_d    = grant_id_q;
    req_ready_d   = '0;
    timeout_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable && found_c) begin
          req_ready_d = NUM_REQ'(1) << sel_c;
          tx_data_d   = sel_byte_c;
          grant_id_d  = sel_c;
          ptr_d       = sel_c;
          tx_sta_d    = 1'b1;
          busy_d      = 1'b1;
          cnt_d       = '0;
          state_d     = SEND;
        end
      end
      SEND: begin
        // Saturate so a long frame can never wrap back into a timeout match.
        if (cnt_q != '1) cnt_d = cnt_q + TO_W'(1);
        if (tx_done) begin
          tx_sta_d = 1'b0;
          gap_d    = '0;
          state_d  = GAP;
        end else if ((timeout_cycles != '0) && (cnt_q == timeout_cycles - TO_W'(1))) begin
          tx_sta_d      = 1'b0;
          timeout_err_d = 1'b1;
          gap_d         = '0;
          state_d       = GAP;
        end
      end
      GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        tx_sta_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= IDX_W'(NUM_REQ - 1);
      cnt_q         <= '0;
      gap_q         <= '0;
      tx_sta_q      <= 1'b0;
      tx_data_q     <= 8'h00;
      req_ready_q   <= '0;
      busy_q        <= 1'b0;
      grant_id_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      gap_q         <= gap_d;
      tx_sta_q      <= tx_sta_d;
      tx_data_q     <= tx_data_d;
      req_ready_q   <= req_ready_d;
      busy_q        <= busy_d;
      grant_id_q    <= grant_id_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign tx_sta      = tx_sta_q;
  assign tx_data     = tx_data_q;
  assign busy        = busy_q;
  assign grant_id    = grant_id_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected grants are queued as stimulus is
// applied and checked whenever the arbiter issues req_ready.
module tb_uart_tx_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned GAP     = 4;
  localparam int unsigned TO_W    = 24;

  typedef struct packed {
    logic [IDX_W-1:0] id;
    logic [7:0]       data;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 enable;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_sta;
  logic [7:0]           tx_data;
  logic                 tx_done;
  logic [TO_W-1:0]      timeout_cycles;
  logic                 busy;
  logic [IDX_W-1:0]     grant_id;
  logic                 timeout_err;

  logic man_done;
  logic auto_pulse;
  int   auto_done;
  int   sta_cnt;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   grants   = 0;
  exp_t exp_q[$];

  assign tx_done = man_done | auto_pulse;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .GAP_CYCLES(GAP), .TO_W(TO_W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .req_valid(req_valid),
    .req_data(req_data), .req_ready(req_ready), .tx_sta(tx_sta),
    .tx_data(tx_data), .tx_done(tx_done), .timeout_cycles(timeout_cycles),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_done();
    man_done = 1'b1;
    cyc(1);
    man_done = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 500) begin
      cyc(1);
      n++;
    end
    check_eq(tag, 32'(busy), 32'd0);
  endtask

  // Transmitter model: returns tx_done auto_done cycles after tx_sta rises.
  initial begin
    auto_pulse = 1'b0;
    sta_cnt    = 0;
    forever begin
      @(negedge clk);
      if (tx_sta) sta_cnt++;
      else sta_cnt = 0;
      auto_pulse = (auto_done != 0) && tx_sta && (sta_cnt == auto_done);
    end
  end

  // Grant monitor: every req_ready must match the head of the expected queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (req_ready !== '0) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_ready", 32'(req_ready), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("gnt_ready", 32'(req_ready), 32'(4'b0001 << e.id));
          check_eq("gnt_id", 32'(grant_id), 32'(e.id));
          check_eq("gnt_data", 32'(tx_data), 32'(e.data));
          check_eq("gnt_sta", 32'(tx_sta), 32'd1);
        end
        grants++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int errs;
    int base;
    rst = 1'b1; enable = 1'b0; req_valid = '0; req_data = '0;
    man_done = 1'b0; timeout_cycles = '0; auto_done = 0;
    cyc(2);
    check_eq("rst_sta", 32'(tx_sta), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_gid", 32'(grant_id), 32'd0);
    check_eq("rst_data", 32'(tx_data), 32'd0);
    check_eq("rst_toerr", 32'(timeout_err), 32'd0);
    rst = 1'b0;

    // Single request, one-cycle grant latency, then done and gap.
    req_valid = 4'b0001; req_data = 32'h0000_00A5; enable = 1'b1;
    exp_q.push_back('{id: 2'd0, data: 8'hA5});
    cyc(1);
    check_eq("t1_busy", 32'(busy), 32'd1);
    req_valid = '0;
    cyc(1);
    check_eq("t1_ready_1cyc", 32'(req_ready), 32'd0);
    check_eq("t1_sta_held", 32'(tx_sta), 32'd1);
    pulse_done();
    check_eq("t1_sta_fall", 32'(tx_sta), 32'd0);
    cyc(GAP - 1);
    check_eq("t1_busy_gap", 32'(busy), 32'd1);
    cyc(1);
    check_eq("t1_busy_low", 32'(busy), 32'd0);
    check_eq("t1_gid_kept", 32'(grant_id), 32'd0);

    // All requesters valid: rotation 0,1,2,3,0,1 after reset.
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    for (int i = 0; i < 6; i++)
      exp_q.push_back('{id: IDX_W'(i % 4), data: 8'(8'h11 * (i % 4 + 1))});
    base = grants;
    req_data = 32'h4433_2211; req_valid = 4'b1111; auto_done = 10;
    n = 0;
    while (grants < base + 6 && n < 1000) begin
      cyc(1);
      n++;
    end
    req_valid = '0;
    check_eq("t2_grant_cnt", 32'(grants - base), 32'd6);
    wait_idle("t2_idle");
    auto_done = 0;

    // Timeout of 50 cycles with no tx_done.
    timeout_cycles = 24'd50;
    req_valid = 4'b0010; req_data = 32'h0000_5A00;
    exp_q.push_back('{id: 2'd1, data: 8'h5A});
    cyc(1);
    req_valid = '0;
    check_eq("t3_sta_rise", 32'(tx_sta), 32'd1);
    n = 0;
    while (tx_sta && n < 200) begin
      cyc(1);
      n++;
    end
    check_eq("t3_to_len", 32'(n), 32'd50);
    check_eq("t3_to_err", 32'(timeout_err), 32'd1);
    cyc(1);
    check_eq("t3_to_err_1cyc", 32'(timeout_err), 32'd0);
    wait_idle("t3_idle");

    // Timeout disabled: tx_sta stays high for 1000 cycles.
    timeout_cycles = '0;
    req_valid = 4'b0100; req_data = 32'h00C3_0000;
    exp_q.push_back('{id: 2'd2, data: 8'hC3});
    cyc(1);
    req_valid = '0;
    n = 0; errs = 0;
    repeat (1000) begin
      cyc(1);
      if (tx_sta) n++;
      if (timeout_err) errs++;
    end
    check_eq("t3b_high", 32'(n), 32'd1000);
    check_eq("t3b_no_err", 32'(errs), 32'd0);
    pulse_done();
    wait_idle("t3b_idle");

    // tx_done coincides with the timeout cycle: done wins.
    timeout_cycles = 24'd20;
    req_valid = 4'b1000; req_data = 32'h3C00_0000;
    exp_q.push_back('{id: 2'd3, data: 8'h3C});
    cyc(1);
    req_valid = '0;
    cyc(19);
    pulse_done();
    check_eq("t4_sta_fall", 32'(tx_sta), 32'd0);
    check_eq("t4_no_err", 32'(timeout_err), 32'd0);
    check_eq("t4_in_gap", 32'(busy), 32'd1);
    cyc(1);
    check_eq("t4_no_err2", 32'(timeout_err), 32'd0);
    wait_idle("t4_idle");
    timeout_cycles = '0;

    // enable dropped mid-frame: frame completes, no new grant until enabled.
    req_valid = 4'b0001; req_data = 32'h0000_8877;
    exp_q.push_back('{id: 2'd0, data: 8'h77});
    cyc(1);
    req_valid = 4'b0110; enable = 1'b0;
    cyc(3);
    check_eq("t5_sta_held", 32'(tx_sta), 32'd1);
    pulse_done();
    wait_idle("t5_idle");
    cyc(20);
    check_eq("t5_no_grant", 32'(busy), 32'd0);
    exp_q.push_back('{id: 2'd1, data: 8'h88});
    enable = 1'b1;
    cyc(1);
    check_eq("t5_resume_gid", 32'(grant_id), 32'd1);

    // Reset mid-frame aborts; first grant afterwards goes to requester 0.
    req_valid = 4'b1111; req_data = 32'h4433_2211;
    cyc(5);
    rst = 1'b1;
    cyc(1);
    check_eq("t6_sta", 32'(tx_sta), 32'd0);
    check_eq("t6_busy", 32'(busy), 32'd0);
    check_eq("t6_gid", 32'(grant_id), 32'd0);
    check_eq("t6_ready", 32'(req_ready), 32'd0);
    check_eq("t6_data", 32'(tx_data), 32'd0);
    exp_q.push_back('{id: 2'd0, data: 8'h11});
    rst = 1'b0;
    cyc(1);
    check_eq("t6_first_gid", 32'(grant_id), 32'd0);
    check_eq("t6_first_sta", 32'(tx_sta), 32'd1);
    req_valid = '0;
    pulse_done();
    wait_idle("t6_idle");
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
